// File: rtl/data_mem_arbiter_if.sv
// Request/acknowledge bus between requesters A and B, the arbiter and data_mem.
// The arbiter takes the slave view; the requester/memory side takes the master view.
interface data_mem_arbiter_if #(
    parameter int WIDTH = 8
);
    logic             A_REQ;
    logic             A_WR;
    logic [WIDTH-1:0] A_ADDR;
    logic [WIDTH-1:0] A_WDATA;
    logic             A_ACK;
    logic [WIDTH-1:0] A_RDATA;

    logic             B_REQ;
    logic             B_WR;
    logic [WIDTH-1:0] B_ADDR;
    logic [WIDTH-1:0] B_WDATA;
    logic             B_ACK;
    logic [WIDTH-1:0] B_RDATA;

    logic             MEM_EN;
    logic             MEM_WR;
    logic [WIDTH-1:0] MEM_ADDR;
    logic [WIDTH-1:0] MEM_D_IN;
    logic [WIDTH-1:0] MEM_D_OUT;

    logic             BUSY;
    logic             OWNER;

    modport slave (
        input  A_REQ, A_WR, A_ADDR, A_WDATA,
        output A_ACK, A_RDATA,
        input  B_REQ, B_WR, B_ADDR, B_WDATA,
        output B_ACK, B_RDATA,
        output MEM_EN, MEM_WR, MEM_ADDR, MEM_D_IN,
        input  MEM_D_OUT,
        output BUSY, OWNER
    );

    modport master (
        output A_REQ, A_WR, A_ADDR, A_WDATA,
        input  A_ACK, A_RDATA,
        output B_REQ, B_WR, B_ADDR, B_WDATA,
        input  B_ACK, B_RDATA,
        input  MEM_EN, MEM_WR, MEM_ADDR, MEM_D_IN,
        output MEM_D_OUT,
        input  BUSY, OWNER
    );
endinterface

// File: rtl/data_mem_arbiter.sv
// Shares single-port data_mem between priority port A and port B; every grant is one
// IDLE->ISSUE->DONE access, with a starvation counter forcing a B grant after a run of A grants.
module data_mem_arbiter #(
    parameter int WIDTH        = 8,
    parameter int STARVE_LIMIT = 3
) (
    input  logic               CLK,
    input  logic               RST,
    data_mem_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    state_t           state_q, state_d;
    logic             owner_q, owner_d;
    logic             op_wr_q, op_wr_d;
    logic             mem_en_q, mem_en_d;
    logic             mem_wr_q, mem_wr_d;
    logic [WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [WIDTH-1:0] mem_d_in_q, mem_d_in_d;
    logic [WIDTH-1:0] a_rdata_q, a_rdata_d;
    logic [WIDTH-1:0] b_rdata_q, b_rdata_d;
    logic             a_ack_q, a_ack_d;
    logic             b_ack_q, b_ack_d;
    logic             busy_q, busy_d;
    logic [3:0]       starve_cnt_q, starve_cnt_d;

    logic             grant_b;
    logic             win_wr;
    logic [WIDTH-1:0] win_addr;
    logic [WIDTH-1:0] win_wdata;

    // B wins only when alone or when A has had its full run of grants against a waiting B.
    assign grant_b   = bus.B_REQ && (!bus.A_REQ || (starve_cnt_q == LIMIT));
    assign win_wr    = grant_b ? bus.B_WR    : bus.A_WR;
    assign win_addr  = grant_b ? bus.B_ADDR  : bus.A_ADDR;
    assign win_wdata = grant_b ? bus.B_WDATA : bus.A_WDATA;

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        op_wr_d      = op_wr_q;
        mem_en_d     = mem_en_q;
        mem_wr_d     = mem_wr_q;
        mem_addr_d   = mem_addr_q;
        mem_d_in_d   = mem_d_in_q;
        a_rdata_d    = a_rdata_q;
        b_rdata_d    = b_rdata_q;
        a_ack_d      = 1'b0;
        b_ack_d      = 1'b0;
        busy_d       = busy_q;
        starve_cnt_d = starve_cnt_q;

        case (state_q)
            IDLE: begin
                if (!bus.B_REQ) begin
                    starve_cnt_d = 4'd0;
                end
                if (bus.A_REQ || bus.B_REQ) begin
                    state_d    = ISSUE;
                    busy_d     = 1'b1;
                    owner_d    = grant_b;
                    op_wr_d    = win_wr;
                    mem_en_d   = 1'b1;
                    mem_wr_d   = win_wr;
                    mem_addr_d = win_addr;
                    if (win_wr) begin
                        mem_d_in_d = win_wdata;
                    end
                    if (grant_b) begin
                        starve_cnt_d = 4'd0;
                    end else if (bus.B_REQ && (starve_cnt_q < LIMIT)) begin
                        starve_cnt_d = starve_cnt_q + 4'd1;
                    end
                end
            end
            ISSUE: begin
                state_d  = DONE;
                mem_en_d = 1'b0;
                mem_wr_d = 1'b0;
                a_ack_d  = !owner_q;
                b_ack_d  = owner_q;
            end
            DONE: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                if (!op_wr_q) begin
                    if (owner_q) begin
                        b_rdata_d = bus.MEM_D_OUT;
                    end else begin
                        a_rdata_d = bus.MEM_D_OUT;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q      <= IDLE;
            owner_q      <= 1'b0;
            op_wr_q      <= 1'b0;
            mem_en_q     <= 1'b0;
            mem_wr_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_d_in_q   <= '0;
            a_rdata_q    <= '0;
            b_rdata_q    <= '0;
            a_ack_q      <= 1'b0;
            b_ack_q      <= 1'b0;
            busy_q       <= 1'b0;
            starve_cnt_q <= 4'd0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            op_wr_q      <= op_wr_d;
            mem_en_q     <= mem_en_d;
            mem_wr_q     <= mem_wr_d;
            mem_addr_q   <= mem_addr_d;
            mem_d_in_q   <= mem_d_in_d;
            a_rdata_q    <= a_rdata_d;
            b_rdata_q    <= b_rdata_d;
            a_ack_q      <= a_ack_d;
            b_ack_q      <= b_ack_d;
            busy_q       <= busy_d;
            starve_cnt_q <= starve_cnt_d;
        end
    end

    // Read data passes straight through from memory while the owner's ACK is up.
    assign bus.A_RDATA  = (state_q == DONE && !owner_q && !op_wr_q) ? bus.MEM_D_OUT : a_rdata_q;
    assign bus.B_RDATA  = (state_q == DONE &&  owner_q && !op_wr_q) ? bus.MEM_D_OUT : b_rdata_q;
    assign bus.A_ACK    = a_ack_q;
    assign bus.B_ACK    = b_ack_q;
    assign bus.MEM_EN   = mem_en_q;
    assign bus.MEM_WR   = mem_wr_q;
    assign bus.MEM_ADDR = mem_addr_q;
    assign bus.MEM_D_IN = mem_d_in_q;
    assign bus.BUSY     = busy_q;
    assign bus.OWNER    = owner_q;
endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed bench for data_mem_arbiter with a behavioural single-port data_mem.
module tb_data_mem_arbiter;
    logic CLK;
    logic RST;
    int   n_tests = 0;
    int   n_fail  = 0;
    logic [7:0] shadow_a = 8'h00;
    logic [7:0] shadow_b = 8'h00;
    logic [7:0] mem [256];
    logic [7:0] mem_dout;
    logic [7:0] exp_owner [8];

    data_mem_arbiter_if #(.WIDTH(8)) bus ();

    data_mem_arbiter #(.WIDTH(8), .STARVE_LIMIT(3)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus.slave)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // data_mem: write and registered read on EN
    always @(posedge CLK) begin
        if (bus.MEM_EN) begin
            if (bus.MEM_WR) mem[bus.MEM_ADDR] <= bus.MEM_D_IN;
            mem_dout <= mem[bus.MEM_ADDR];
        end
    end
    assign bus.MEM_D_OUT = mem_dout;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Walks one granted access from the grant edge to the following IDLE cycle.
    task automatic serve(input bit exp_b, input bit wr, input logic [7:0] addr,
                         input logic [7:0] wdata, input logic [7:0] rd, input bit drop_req);
        @(posedge CLK); #1;
        check("issue_en",    bus.MEM_EN, 1);
        check("issue_busy",  bus.BUSY, 1);
        check("issue_owner", bus.OWNER, exp_b);
        check("issue_wr",    bus.MEM_WR, wr);
        check("issue_addr",  bus.MEM_ADDR, addr);
        if (wr) check("issue_din", bus.MEM_D_IN, wdata);
        check("issue_ack_a", bus.A_ACK, 0);
        check("issue_ack_b", bus.B_ACK, 0);
        if (drop_req) begin
            if (exp_b) begin
                bus.B_REQ = 1'b0; bus.B_WR = ~wr; bus.B_ADDR = ~addr; bus.B_WDATA = ~wdata;
            end else begin
                bus.A_REQ = 1'b0; bus.A_WR = ~wr; bus.A_ADDR = ~addr; bus.A_WDATA = ~wdata;
            end
        end
        @(posedge CLK); #1;
        check("done_ack_a", bus.A_ACK, !exp_b);
        check("done_ack_b", bus.B_ACK, exp_b);
        check("done_en",    bus.MEM_EN, 0);
        check("done_wr",    bus.MEM_WR, 0);
        check("done_addr",  bus.MEM_ADDR, addr);
        check("done_busy",  bus.BUSY, 1);
        if (!wr) begin
            if (exp_b) begin check("done_rdata_b", bus.B_RDATA, rd); shadow_b = rd; end
            else       begin check("done_rdata_a", bus.A_RDATA, rd); shadow_a = rd; end
        end else begin
            if (exp_b) check("done_wkeep_b", bus.B_RDATA, shadow_b);
            else       check("done_wkeep_a", bus.A_RDATA, shadow_a);
        end
        $display("[TB] txn port=%s %s addr=%02h data=%02h", exp_b ? "B" : "A",
                 wr ? "WR" : "RD", addr, wr ? wdata : rd);
        @(posedge CLK); #1;
        check("idle_ack_a", bus.A_ACK, 0);
        check("idle_ack_b", bus.B_ACK, 0);
        check("idle_busy",  bus.BUSY, 0);
        check("idle_rd_a",  bus.A_RDATA, shadow_a);
        check("idle_rd_b",  bus.B_RDATA, shadow_b);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_owner = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        // 1: reset held with both requesting
        RST = 1'b1;
        bus.A_REQ = 1'b1; bus.A_WR = 1'b0; bus.A_ADDR = 8'h00; bus.A_WDATA = 8'h00;
        bus.B_REQ = 1'b1; bus.B_WR = 1'b0; bus.B_ADDR = 8'h00; bus.B_WDATA = 8'h00;
        repeat (2) @(posedge CLK);
        #1;
        check("rst_en",    bus.MEM_EN, 0);
        check("rst_wr",    bus.MEM_WR, 0);
        check("rst_addr",  bus.MEM_ADDR, 0);
        check("rst_din",   bus.MEM_D_IN, 0);
        check("rst_busy",  bus.BUSY, 0);
        check("rst_owner", bus.OWNER, 0);
        check("rst_ack_a", bus.A_ACK, 0);
        check("rst_ack_b", bus.B_ACK, 0);
        check("rst_rd_a",  bus.A_RDATA, 0);
        check("rst_rd_b",  bus.B_RDATA, 0);
        RST = 1'b0;
        bus.B_REQ = 1'b0;
        bus.A_WR = 1'b1; bus.A_ADDR = 8'h00; bus.A_WDATA = 8'h11;
        serve(0, 1, 8'h00, 8'h11, 8'h00, 1);

        // 2: A write then read back
        bus.A_REQ = 1'b1; bus.A_WR = 1'b1; bus.A_ADDR = 8'h10; bus.A_WDATA = 8'h5A;
        serve(0, 1, 8'h10, 8'h5A, 8'h00, 1);
        bus.A_REQ = 1'b1; bus.A_WR = 1'b0; bus.A_ADDR = 8'h10;
        serve(0, 0, 8'h10, 8'h00, 8'h5A, 1);

        // 3: simultaneous A write and B read of the same address
        bus.A_REQ = 1'b1; bus.A_WR = 1'b1; bus.A_ADDR = 8'h20; bus.A_WDATA = 8'hC3;
        bus.B_REQ = 1'b1; bus.B_WR = 1'b0; bus.B_ADDR = 8'h20;
        serve(0, 1, 8'h20, 8'hC3, 8'h00, 1);
        serve(1, 0, 8'h20, 8'h00, 8'hC3, 1);

        // 4: both held continuously, starvation limit 3
        bus.A_REQ = 1'b1; bus.A_WR = 1'b0; bus.A_ADDR = 8'h10;
        bus.B_REQ = 1'b1; bus.B_WR = 1'b0; bus.B_ADDR = 8'h20;
        for (int k = 0; k < 8; k++) begin
            if (exp_owner[k]) serve(1, 0, 8'h20, 8'h00, 8'hC3, 0);
            else              serve(0, 0, 8'h10, 8'h00, 8'h5A, 0);
        end
        bus.A_REQ = 1'b0; bus.B_REQ = 1'b0;
        @(posedge CLK); #1;
        check("starve_idle_busy", bus.BUSY, 0);

        // 6: reset during ISSUE of an A read, then re-issue
        bus.A_REQ = 1'b1; bus.A_WR = 1'b1; bus.A_ADDR = 8'h30; bus.A_WDATA = 8'h77;
        serve(0, 1, 8'h30, 8'h77, 8'h00, 1);
        bus.A_REQ = 1'b1; bus.A_WR = 1'b0; bus.A_ADDR = 8'h30;
        @(posedge CLK); #1;
        check("abort_issue_en", bus.MEM_EN, 1);
        RST = 1'b1;
        @(posedge CLK); #1;
        check("abort_busy",  bus.BUSY, 0);
        check("abort_ack_a", bus.A_ACK, 0);
        check("abort_en",    bus.MEM_EN, 0);
        check("abort_rd_a",  bus.A_RDATA, 0);
        shadow_a = 8'h00; shadow_b = 8'h00;
        RST = 1'b0;
        serve(0, 0, 8'h30, 8'h00, 8'h77, 1);

        // 5: B fills the whole memory then reads it back
        for (int i = 0; i < 256; i++) begin
            bus.B_REQ = 1'b1; bus.B_WR = 1'b1; bus.B_ADDR = 8'(i); bus.B_WDATA = 8'(i * 5);
            serve(1, 1, 8'(i), 8'(i * 5), 8'h00, 1);
        end
        for (int i = 0; i < 256; i++) begin
            bus.B_REQ = 1'b1; bus.B_WR = 1'b0; bus.B_ADDR = 8'(i);
            serve(1, 0, 8'(i), 8'h00, 8'(i * 5), 1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/data_mem_arbiter.md
Name: data_mem_arbiter

Overview:
Two-port arbiter and sequencer in front of the single-port data_mem. It shares the memory between requester A (CPU load/store unit, priority port) and requester B (debug/DMA loader). Each granted request becomes one EN-qualified memory access. A starvation counter guarantees B is served when A keeps requesting.

Parameters:
WIDTH, 8, data and address width; memory depth is 2^WIDTH.
STARVE_LIMIT, 3, maximum consecutive A grants while B_REQ is held; range 1..15.

Ports:
CLK  in  1  system clock, rising edge
RST  in  1  synchronous reset, active-high
A_REQ  in  1  port A request; hold with A_WR/A_ADDR/A_WDATA stable until A_ACK
A_WR  in  1  1 = write, 0 = read
A_ADDR  in  WIDTH  port A address
A_WDATA  in  WIDTH  port A write data
A_ACK  out  1  one-cycle completion pulse
A_RDATA  out  WIDTH  port A read data, valid while A_ACK=1 for reads
B_REQ, B_WR, B_ADDR, B_WDATA, B_ACK, B_RDATA  same directions, widths and meanings for port B
MEM_EN  out  1  to data_mem EN
MEM_WR  out  1  to data_mem write enable
MEM_ADDR  out  WIDTH  to data_mem ADDR
MEM_D_IN  out  WIDTH  to data_mem D_IN
MEM_D_OUT  in  WIDTH  from data_mem D_OUT; registered read, valid the cycle after MEM_EN
BUSY  out  1  1 when state is not IDLE
OWNER  out  1  0 = A, 1 = B; meaningful only while BUSY=1

Behaviour:
- Reset: the clock edge that samples RST=1 sets state=IDLE, starve_cnt=0, and MEM_EN, MEM_WR, MEM_ADDR, MEM_D_IN, A_RDATA, B_RDATA, OWNER to 0. A_ACK, B_ACK and BUSY are 0 during IDLE.
- FSM states: IDLE, ISSUE, DONE.
  - IDLE -> ISSUE on any REQ=1. Arbitration is decided at this edge.
  - ISSUE -> DONE unconditionally.
  - DONE -> IDLE unconditionally.
- All MEM_* outputs and OWNER are registered.
- IDLE -> ISSUE edge: MEM_ADDR, MEM_WR and MEM_D_IN are loaded from the winner. MEM_EN=1 only during ISSUE.
- Write: memory writes at the edge ending ISSUE. The MEM_D_IN register is updated only for writes.
- DONE: MEM_EN=0, MEM_WR=0, MEM_ADDR held. The owner's ACK=1 (Moore output).
  - For reads, owner RDATA = MEM_D_OUT during DONE (combinational mux).
  - Owner's RDATA register loads MEM_D_OUT at the edge ending DONE; RDATA holds that value afterwards.
  - For writes, RDATA is unchanged.
- Latency: REQ sampled in cycle t -> MEM_EN in t+1 -> ACK in t+2. Throughput is one access per 3 cycles. A requester keeping REQ high after ACK starts a new transaction, sampled in the following IDLE cycle.
- Arbitration in IDLE:
  - Only A_REQ -> A. Only B_REQ -> B.
  - Both -> A, unless starve_cnt == STARVE_LIMIT, in which case B wins.
- starve_cnt (4-bit):
  - +1 on each A grant while B_REQ=1.
  - Cleared on a B grant or in any IDLE cycle with B_REQ=0.
  - Saturates at STARVE_LIMIT.
- Transaction attributes are captured at grant. Dropping REQ or changing inputs after grant does not abort or alter the access; ACK still pulses.
- The non-owner's ACK stays 0 throughout. A and B ACKs are never high in the same cycle.
- Address arithmetic: MEM_ADDR is a direct copy, no offset. 2^WIDTH-1 is a valid address; there is no wrap logic inside the block.
- Reset mid-operation: RST wins over all transitions. No ACK is issued for the aborted transaction; the requester must re-issue.
  - A write in ISSUE when RST rises may still commit at that edge, because data_mem sees EN=1. This is permitted.
  - Normal operation resumes in the IDLE cycle after RST deasserts.

Test Plan:
1. RST=1 for 2 cycles with A_REQ=B_REQ=1 -> all outputs 0, BUSY=0, no MEM_EN; first grant occurs on the edge after RST falls.
2. A write 8'h10<=8'h5A, then A read 8'h10 -> MEM_EN in t+1, A_ACK in t+2 for each; read A_RDATA=8'h5A with A_ACK high and held afterwards.
3. Same cycle: A write 8'h20<=8'hC3 and B read 8'h20 -> A_ACK first; B_ACK exactly 3 cycles later with B_RDATA=8'hC3.
4. A_REQ and B_REQ held high continuously, STARVE_LIMIT=3 -> OWNER grant sequence A,A,A,B,A,A,A,B; starve_cnt is 0 after each B grant.
5. B writes D=5*i (mod 256) to all addresses 8'h00..8'hFF, then reads them all back -> every B_RDATA matches, including address 8'hFF; A is never acknowledged.
6. RST asserted during ISSUE of an A read at 8'h30 -> no A_ACK; BUSY=0 next cycle; re-issued read completes with correct data 3 cycles after grant.
